// File: rtl/sram_sp_ctrl_if.sv
// Bundle between the single-port SRAM controller, its request/response
// clients and the SRAM macro pins.
interface sram_sp_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              init_done;
    logic              w_valid;
    logic              w_ready;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              r_req_valid;
    logic              r_req_ready;
    logic [ADDR_W-1:0] r_addr;
    logic              r_resp_valid;
    logic              r_resp_ready;
    logic [DATA_W-1:0] r_resp_data;
    logic              sram_ceb;
    logic              sram_web;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_d;
    logic [DATA_W-1:0] sram_q;

    // master: clients plus the macro (which supplies sram_q)
    modport master (
        output w_valid, w_addr, w_data,
        output r_req_valid, r_addr, r_resp_ready,
        output sram_q,
        input  init_done, w_ready, r_req_ready, r_resp_valid, r_resp_data,
        input  sram_ceb, sram_web, sram_a, sram_d
    );

    modport slave (
        input  w_valid, w_addr, w_data,
        input  r_req_valid, r_addr, r_resp_ready,
        input  sram_q,
        output init_done, w_ready, r_req_ready, r_resp_valid, r_resp_data,
        output sram_ceb, sram_web, sram_a, sram_d
    );
endinterface

// File: rtl/sram_sp_ctrl.sv
// Single-port SRAM controller: zero-fills the macro after reset, then
// arbitrates write and read channels onto the port with a skid-held response.
module sram_sp_ctrl #(
    parameter int              DATA_W   = 8,
    parameter int              DEPTH    = 256,
    parameter int              ADDR_W   = 8,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic          clock,
    input  logic          reset,
    sram_sp_ctrl_if.slave bus
);
    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam logic [ADDR_W:0] INIT_LAST = (ADDR_W+1)'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W:0]   init_cnt;
    logic              prio_rd;
    logic              rd_pend;
    logic              hold_vld;
    logic [DATA_W-1:0] hold_data;

    logic              resp_vld;
    logic              rd_ok;
    logic              w_req;
    logic              r_req;
    logic              w_gnt;
    logic              r_gnt;

    always_comb begin
        resp_vld = rd_pend | hold_vld;
        rd_ok    = !(resp_vld && !bus.r_resp_ready);
        w_req    = !reset && (state == ST_RUN) && bus.w_valid;
        r_req    = !reset && (state == ST_RUN) && bus.r_req_valid && rd_ok;
        // prio_rd remembers that the write won the last contention
        w_gnt    = w_req && !(r_req && prio_rd);
        r_gnt    = r_req && !w_gnt;
    end

    always_comb begin
        bus.sram_ceb = 1'b1;
        bus.sram_web = 1'b1;
        bus.sram_a   = '0;
        bus.sram_d   = '0;
        if (!reset) begin
            if (state == ST_INIT) begin
                bus.sram_ceb = 1'b0;
                bus.sram_web = 1'b0;
                bus.sram_a   = init_cnt[ADDR_W-1:0];
                bus.sram_d   = INIT_VAL;
            end else if (w_gnt) begin
                bus.sram_ceb = 1'b0;
                bus.sram_web = 1'b0;
                bus.sram_a   = bus.w_addr;
                bus.sram_d   = bus.w_data;
            end else if (r_gnt) begin
                bus.sram_ceb = 1'b0;
                bus.sram_a   = bus.r_addr;
            end
        end
    end

    always_comb begin
        bus.init_done    = !reset && (state == ST_RUN);
        bus.w_ready      = w_gnt;
        bus.r_req_ready  = r_gnt;
        bus.r_resp_valid = !reset && resp_vld;
        bus.r_resp_data  = '0;
        // Q is only meaningful the cycle after a read; afterwards use the hold copy
        if (!reset) begin
            if (hold_vld)
                bus.r_resp_data = hold_data;
            else if (rd_pend)
                bus.r_resp_data = bus.sram_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            prio_rd   <= 1'b0;
            rd_pend   <= 1'b0;
            hold_vld  <= 1'b0;
            hold_data <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == INIT_LAST)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_req && r_req)
                        prio_rd <= w_gnt;
                end
                default: state <= ST_INIT;
            endcase

            rd_pend <= r_gnt;
            if (rd_pend && !bus.r_resp_ready) begin
                hold_vld  <= 1'b1;
                hold_data <= bus.sram_q;
            end else if (hold_vld && bus.r_resp_ready) begin
                hold_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sram_sp_ctrl.sv
// Scoreboard bench for sram_sp_ctrl with a behavioural 256x8 macro and a
// queue-based reference of memory contents and outstanding read responses.
module tb_sram_sp_ctrl;
    logic clock;
    logic reset;
    int   tests;
    int   fails;

    sram_sp_ctrl_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    sram_sp_ctrl #(
        .DATA_W  (8),
        .DEPTH   (256),
        .ADDR_W  (8),
        .INIT_VAL(8'h00)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Macro: Q valid only after a read, otherwise garbage
    logic [7:0] macro_mem [256];
    always @(posedge clock) begin
        if (!bus.sram_ceb && bus.sram_web)
            bus.sram_q <= macro_mem[bus.sram_a];
        else
            bus.sram_q <= 8'($urandom);
        if (!bus.sram_ceb && !bus.sram_web)
            macro_mem[bus.sram_a] <= bus.sram_d;
    end

    function automatic void chk(string nm, int unsigned act, int unsigned exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model state
    logic [7:0] m_mem [256];
    logic [7:0] exp_q [$];
    bit         m_init = 1'b1;
    int         m_cnt = 0;
    bit         m_prio_rd = 1'b0;
    bit         rv_exp, rd_ok, wreq, rreq, gw, gr;

    always @(negedge clock) begin
        if (reset) begin
            chk("rst_ceb", bus.sram_ceb, 1);
            chk("rst_web", bus.sram_web, 1);
            chk("rst_init_done", bus.init_done, 0);
            chk("rst_w_ready", bus.w_ready, 0);
            chk("rst_r_req_ready", bus.r_req_ready, 0);
            chk("rst_resp_valid", bus.r_resp_valid, 0);
            chk("rst_resp_data", bus.r_resp_data, 0);
            m_init    = 1'b1;
            m_cnt     = 0;
            m_prio_rd = 1'b0;
            exp_q.delete();
        end else if (m_init) begin
            chk("init_ceb", bus.sram_ceb, 0);
            chk("init_web", bus.sram_web, 0);
            chk("init_addr", bus.sram_a, m_cnt);
            chk("init_data", bus.sram_d, 0);
            chk("init_done_low", bus.init_done, 0);
            chk("init_w_ready", bus.w_ready, 0);
            chk("init_r_req_ready", bus.r_req_ready, 0);
            chk("init_resp_valid", bus.r_resp_valid, 0);
            m_mem[m_cnt] = 8'h00;
            m_cnt++;
            if (m_cnt == 256) m_init = 1'b0;
        end else begin
            rv_exp = (exp_q.size() != 0);
            chk("init_done", bus.init_done, 1);
            chk("resp_valid", bus.r_resp_valid, rv_exp);
            if (rv_exp) chk("resp_data", bus.r_resp_data, exp_q[0]);
            rd_ok = !(rv_exp && !bus.r_resp_ready);
            wreq  = bus.w_valid;
            rreq  = bus.r_req_valid && rd_ok;
            gw    = wreq && !(rreq && m_prio_rd);
            gr    = rreq && !gw;
            chk("w_ready", bus.w_ready, gw);
            chk("r_req_ready", bus.r_req_ready, gr);
            chk("ceb", bus.sram_ceb, !(gw || gr));
            if (gw) begin
                chk("wr_web", bus.sram_web, 0);
                chk("wr_addr", bus.sram_a, bus.w_addr);
                chk("wr_data", bus.sram_d, bus.w_data);
                m_mem[bus.w_addr] = bus.w_data;
            end
            if (gr) begin
                chk("rd_web", bus.sram_web, 1);
                chk("rd_addr", bus.sram_a, bus.r_addr);
                chk("rd_d_zero", bus.sram_d, 0);
            end
            if (rv_exp && bus.r_resp_ready) void'(exp_q.pop_front());
            if (gr) exp_q.push_back(m_mem[bus.r_addr]);
            if (wreq && rreq) m_prio_rd = gw;
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.w_valid      = 1'b0;
        bus.w_addr       = '0;
        bus.w_data       = '0;
        bus.r_req_valid  = 1'b0;
        bus.r_addr       = '0;
        bus.r_resp_ready = 1'b1;
    endtask

    task automatic wait_init(string nm);
        int n = 0;
        while (!bus.init_done && n < 400) begin
            cyc();
            n++;
        end
        chk(nm, n, 256);
    endtask

    task automatic do_write(logic [7:0] a, logic [7:0] d);
        bit ok = 1'b0;
        int n = 0;
        bus.w_valid = 1'b1;
        bus.w_addr  = a;
        bus.w_data  = d;
        while (!ok && n < 50) begin
            @(negedge clock);
            ok = bus.w_ready;
            cyc();
            n++;
        end
        if (!ok) chk("write_timeout", 0, 1);
        bus.w_valid = 1'b0;
    endtask

    task automatic do_read(logic [7:0] a);
        bit ok = 1'b0;
        int n = 0;
        bus.r_req_valid = 1'b1;
        bus.r_addr      = a;
        while (!ok && n < 50) begin
            @(negedge clock);
            ok = bus.r_req_ready;
            cyc();
            n++;
        end
        if (!ok) chk("read_timeout", 0, 1);
        bus.r_req_valid = 1'b0;
    endtask

    task automatic read_expect(string nm, logic [7:0] a, logic [7:0] d);
        do_read(a);
        @(negedge clock);
        chk({nm, "_valid"}, bus.r_resp_valid, 1);
        chk({nm, "_data"}, bus.r_resp_data, d);
        cyc();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string seq;
        tests = 0;
        fails = 0;
        idle();
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        wait_init("init_cycles");
        read_expect("rd_7f", 8'h7f, 8'h00);

        do_write(8'h10, 8'ha5);
        read_expect("wr_rd_10", 8'h10, 8'ha5);

        // Backpressure: response held while Q is garbage
        bus.r_resp_ready = 1'b0;
        do_read(8'h10);
        bus.r_req_valid = 1'b1;
        bus.r_addr      = 8'h11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_valid", bus.r_resp_valid, 1);
            chk("bp_data", bus.r_resp_data, 8'ha5);
            chk("bp_r_req_ready", bus.r_req_ready, 0);
            chk("bp_ceb", bus.sram_ceb, 1);
            cyc();
        end
        bus.r_req_valid  = 1'b0;
        bus.r_resp_ready = 1'b1;
        @(negedge clock);
        chk("bp_accept_data", bus.r_resp_data, 8'ha5);
        cyc();
        @(negedge clock);
        chk("bp_valid_drop", bus.r_resp_valid, 0);
        cyc();

        // Contention: expect W,R,W,R
        bus.w_valid     = 1'b1;
        bus.w_addr      = 8'h20;
        bus.w_data      = 8'h5a;
        bus.r_req_valid = 1'b1;
        bus.r_addr      = 8'h20;
        seq = "";
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (bus.w_ready) seq = {seq, "W"};
            else if (bus.r_req_ready) seq = {seq, "R"};
            else seq = {seq, "-"};
            if (i == 2) chk("cont_rd_data", bus.r_resp_data, 8'h5a);
            cyc();
        end
        idle();
        tests++;
        if (seq != "WRWR") begin
            fails++;
            $display("FAIL contention_seq: got %s expected WRWR", seq);
        end

        // Back-to-back reads
        for (int i = 0; i < 4; i++) do_write(8'(i), 8'(i + 1));
        for (int i = 0; i < 5; i++) begin
            bus.r_req_valid = (i < 4);
            bus.r_addr      = 8'(i);
            @(negedge clock);
            if (i < 4) chk("b2b_accept", bus.r_req_ready, 1);
            if (i > 0) begin
                chk("b2b_valid", bus.r_resp_valid, 1);
                chk("b2b_data", bus.r_resp_data, i);
            end
            cyc();
        end
        idle();

        // Reset in the middle of initialisation
        do_write(8'h05, 8'h33);
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        repeat (100) cyc();
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        wait_init("reinit_cycles");
        read_expect("rd_05_cleared", 8'h05, 8'h00);

        // Randomised traffic on a narrow address range
        for (int i = 0; i < 2000; i++) begin
            bus.w_valid      = 1'($urandom_range(0, 1));
            bus.w_addr       = 8'($urandom_range(0, 15));
            bus.w_data       = 8'($urandom);
            bus.r_req_valid  = 1'($urandom_range(0, 1));
            bus.r_addr       = 8'($urandom_range(0, 15));
            bus.r_resp_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        idle();
        repeat (4) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
